pll_reset_sequencer: RTL and testbench
======================================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter RESET_HOLD_CYCLES, default 12: number of cycles PLL_RESETB is held low per attempt (1 us at 12 MHz).
REQ-002 Parameter LOCK_TIMEOUT_CYCLES, default 1200: number of cycles allowed in WAIT_LOCK before an attempt is abandoned.
REQ-003 Parameter LOCK_STABLE_CYCLES, default 16: number of consecutive synchronized-lock-high cycles required before release.
REQ-004 Parameter MAX_RETRIES, default 3: number of re-attempts after the first timeout before FAILED.
REQ-005 REFERENCECLK  in  1  sole clock; the PLL reference clock, 12 MHz.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 PLL_LOCK  in  1  PLL LOCK output; asynchronous to REFERENCECLK.
REQ-008 REARM  in  1  single-cycle request to restart the full sequence.
REQ-009 PLL_RESETB  out  1  drives the PLL RESETB input; active low.
REQ-010 SYS_RESET  out  1  active-high reset for logic in the PLL output domain.
REQ-011 LOCKED  out  1  high only in RUN.
REQ-012 FAIL  out  1  high only in FAILED.
REQ-013 RETRY_COUNT  out  2  number of timeouts since the last RESET or REARM; saturates at 3.

Function
REQ-014 PLL_LOCK SHALL pass through a 2-flop synchronizer (lock_s) before use; there is no other use of PLL_LOCK.
REQ-015 States: HOLD, WAIT_LOCK, STABLE, RUN, FAILED; one shared cycle counter, cleared on every state entry.
REQ-016 All outputs SHALL be registered and decoded from the state register only:
- PLL_RESETB = 0 in HOLD and FAILED, 1 otherwise.
- SYS_RESET = 0 only in RUN.
REQ-017 HOLD: after RESET_HOLD_CYCLES cycles in HOLD, go to WAIT_LOCK.
REQ-018 WAIT_LOCK: lock_s = 1 SHALL move to STABLE.
REQ-019 WAIT_LOCK timeout: when the counter reaches LOCK_TIMEOUT_CYCLES-1 with lock_s = 0:
- RETRY_COUNT == MAX_RETRIES: go to FAILED.
- Otherwise: increment RETRY_COUNT and go to HOLD.
REQ-020 Lock takes priority over timeout: if lock_s = 1 on the timeout cycle, go to STABLE.
REQ-021 STABLE: after LOCK_STABLE_CYCLES consecutive cycles with lock_s = 1, go to RUN.
REQ-022 A lock_s = 0 sample in STABLE SHALL return to WAIT_LOCK with a fresh timeout; this does not count as a retry.
REQ-023 RUN: lock_s = 0 (loss of lock) SHALL go to HOLD; SYS_RESET reasserts on the next edge; RETRY_COUNT is unchanged.
REQ-024 FAILED is terminal; it is left only by REARM or RESET.
REQ-025 REARM = 1 in any state SHALL go to HOLD next cycle, clear RETRY_COUNT and clear FAIL; REARM outranks every other transition.
REQ-026 REARM held high for N cycles SHALL keep the block in HOLD with the counter cleared; the hold count starts after REARM falls.
REQ-027 Counter width SHALL be clog2(max(RESET_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES)+1) bits; the counter never wraps within a state.
REQ-028 Latency, PLL_LOCK rise to SYS_RESET fall, with lock held high: 2 + LOCK_STABLE_CYCLES + 1 cycles.
REQ-029 Latency, PLL_LOCK fall in RUN to SYS_RESET rise: 3 cycles.

Reset
REQ-030 RESET = 1 SHALL force the following on the next edge, regardless of PLL_LOCK or REARM:
- state HOLD, counter 0, synchronizer flops 0, RETRY_COUNT 0;
- PLL_RESETB 0, SYS_RESET 1, LOCKED 0, FAIL 0.
REQ-031 RESET asserted mid-sequence (any state) SHALL restart from HOLD identically to power-up.

Verification
All scenarios use RESET_HOLD_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=3, MAX_RETRIES=2.
REQ-032 Release RESET -> PLL_RESETB low exactly 4 cycles, then high; SYS_RESET stays 1.
REQ-033 PLL_LOCK rises 5 cycles after PLL_RESETB rises and stays high -> SYS_RESET falls and LOCKED rises 6 cycles after the PLL_LOCK edge; RETRY_COUNT = 0.
REQ-034 PLL_LOCK high 2 cycles, low 1 cycle, then high steadily -> STABLE aborts to WAIT_LOCK; release occurs 6 cycles after the final rise; RETRY_COUNT = 0.
REQ-035 PLL_LOCK held 0 -> three HOLD/WAIT_LOCK attempts (4 low + 20 high cycles each); RETRY_COUNT goes 1, then 2; after the third timeout FAIL = 1 and PLL_RESETB = 0 permanently.
REQ-036 In RUN, drop PLL_LOCK -> SYS_RESET = 1 and LOCKED = 0 three cycles later; PLL_RESETB then low for 4 cycles; re-lock releases again per REQ-033.
REQ-037 In FAILED, pulse REARM for 1 cycle -> FAIL = 0 and RETRY_COUNT = 0 next cycle; PLL_RESETB low for 4 cycles, then the sequence proceeds; REARM coincident with lock_s rise in WAIT_LOCK -> HOLD, not STABLE.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer
// Purpose  : Holds a PLL in reset, waits for a stable lock, then releases the
//            PLL-domain reset. Retries on lock timeout and gives up after a
//            bounded number of attempts. REARM restarts the whole sequence.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
  parameter int RESET_HOLD_CYCLES   = 12,
  parameter int LOCK_TIMEOUT_CYCLES = 1200,
  parameter int LOCK_STABLE_CYCLES  = 16,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       REFERENCECLK,
  input  logic       RESET,
  input  logic       PLL_LOCK,
  input  logic       REARM,
  output logic       PLL_RESETB,
  output logic       SYS_RESET,
  output logic       LOCKED,
  output logic       FAIL,
  output logic [1:0] RETRY_COUNT
);

  // Counter is sized for the longest interval any state has to measure.
  localparam int c_MAX_HT  = (RESET_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                             RESET_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int c_CNT_MAX = (c_MAX_HT > LOCK_STABLE_CYCLES) ?
                             c_MAX_HT : LOCK_STABLE_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST   = c_CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_STABLE_LAST = c_CNT_W'(LOCK_STABLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAILED    = 3'd4
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [1:0]           r_retry;
  logic                 r_lock_meta;
  logic                 r_lock_s;
  logic                 r_pll_resetb;
  logic                 r_sys_reset;
  logic                 r_locked;
  logic                 r_fail;

  state_t               w_next_state;
  logic [c_CNT_W-1:0]   w_next_cnt;
  logic [1:0]           w_next_retry;

  // Two-flop synchronizer: PLL_LOCK is asynchronous to REFERENCECLK.
  always_ff @(posedge REFERENCECLK) begin
    if (RESET) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= PLL_LOCK;
      r_lock_s    <= r_lock_meta;
    end
  end

  // Next-state, counter and retry decisions; REARM outranks everything.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt + c_CNT_ONE;
    w_next_retry = r_retry;
    if (REARM) begin
      w_next_state = ST_HOLD;
      w_next_cnt   = '0;
      w_next_retry = 2'd0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_cnt == c_HOLD_LAST) begin
            w_next_state = ST_WAIT_LOCK;
            w_next_cnt   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock wins over a timeout falling on the same cycle.
          if (r_lock_s) begin
            w_next_state = ST_STABLE;
            w_next_cnt   = '0;
          end else if (r_cnt == c_TIMEOUT_LAST) begin
            w_next_cnt = '0;
            if (int'(r_retry) == MAX_RETRIES) begin
              w_next_state = ST_FAILED;
            end else begin
              w_next_state = ST_HOLD;
              w_next_retry = (r_retry == 2'd3) ? 2'd3 : r_retry + 2'd1;
            end
          end
        end
        ST_STABLE: begin
          // A single dropout restarts the lock wait without costing a retry.
          if (!r_lock_s) begin
            w_next_state = ST_WAIT_LOCK;
            w_next_cnt   = '0;
          end else if (r_cnt == c_STABLE_LAST) begin
            w_next_state = ST_RUN;
            w_next_cnt   = '0;
          end
        end
        ST_RUN: begin
          w_next_cnt = '0;
          if (!r_lock_s) begin
            w_next_state = ST_HOLD;
          end
        end
        ST_FAILED: begin
          w_next_cnt = '0;
        end
        default: begin
          w_next_state = ST_HOLD;
          w_next_cnt   = '0;
        end
      endcase
    end
  end

  // State, counter and outputs; outputs are decoded from the state being entered
  // so they change on the same edge as the state register.
  always_ff @(posedge REFERENCECLK) begin
    if (RESET) begin
      r_state      <= ST_HOLD;
      r_cnt        <= '0;
      r_retry      <= 2'd0;
      r_pll_resetb <= 1'b0;
      r_sys_reset  <= 1'b1;
      r_locked     <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_next_cnt;
      r_retry      <= w_next_retry;
      r_pll_resetb <= !((w_next_state == ST_HOLD) || (w_next_state == ST_FAILED));
      r_sys_reset  <= (w_next_state != ST_RUN);
      r_locked     <= (w_next_state == ST_RUN);
      r_fail       <= (w_next_state == ST_FAILED);
    end
  end

  assign PLL_RESETB  = r_pll_resetb;
  assign SYS_RESET   = r_sys_reset;
  assign LOCKED      = r_locked;
  assign FAIL        = r_fail;
  assign RETRY_COUNT = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reset_sequencer
// Purpose  : Scenario tests plus randomized comparison against a behavioural
//            model of the PLL reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

  localparam int P_HOLD = 4;
  localparam int P_TO   = 20;
  localparam int P_ST   = 3;
  localparam int P_MR   = 2;

  localparam int PH_HOLD   = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_FAILED = 4;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       lock  = 1'b0;
  logic       rearm = 1'b0;
  logic       resetb;
  logic       sysrst;
  logic       locked;
  logic       failo;
  logic [1:0] retry;

  int errors = 0;
  int checks = 0;

  pll_reset_sequencer #(
    .RESET_HOLD_CYCLES   (P_HOLD),
    .LOCK_TIMEOUT_CYCLES (P_TO),
    .LOCK_STABLE_CYCLES  (P_ST),
    .MAX_RETRIES         (P_MR)
  ) dut (
    .REFERENCECLK (clk),
    .RESET        (rst),
    .PLL_LOCK     (lock),
    .REARM        (rearm),
    .PLL_RESETB   (resetb),
    .SYS_RESET    (sysrst),
    .LOCKED       (locked),
    .FAIL         (failo),
    .RETRY_COUNT  (retry)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_phase = PH_HOLD;
  int m_spent = 0;
  int m_retry = 0;
  bit m_h0 = 1'b0;  // PLL_LOCK seen one edge ago
  bit m_h1 = 1'b0;  // PLL_LOCK seen two edges ago = value the sequencer acts on

  task automatic model_step();
    bit ls;
    ls   = m_h1;
    m_h1 = m_h0;
    m_h0 = lock;
    if (rst) begin
      m_phase = PH_HOLD; m_spent = 0; m_retry = 0; m_h0 = 1'b0; m_h1 = 1'b0;
    end else if (rearm) begin
      m_phase = PH_HOLD; m_spent = 0; m_retry = 0;
    end else begin
      m_spent++;
      case (m_phase)
        PH_HOLD:
          if (m_spent == P_HOLD) begin m_phase = PH_WAIT; m_spent = 0; end
        PH_WAIT:
          if (ls) begin
            m_phase = PH_STABLE; m_spent = 0;
          end else if (m_spent == P_TO) begin
            m_spent = 0;
            if (m_retry == P_MR) m_phase = PH_FAILED;
            else begin
              m_phase = PH_HOLD;
              m_retry = (m_retry < 3) ? m_retry + 1 : 3;
            end
          end
        PH_STABLE:
          if (!ls) begin m_phase = PH_WAIT; m_spent = 0; end
          else if (m_spent == P_ST) begin m_phase = PH_RUN; m_spent = 0; end
        PH_RUN:
          if (!ls) begin m_phase = PH_HOLD; m_spent = 0; end
        default: ;
      endcase
    end
  endtask

  function automatic logic [5:0] m_vec();
    logic rb;
    rb = !((m_phase == PH_HOLD) || (m_phase == PH_FAILED));
    return {rb, (m_phase != PH_RUN), (m_phase == PH_RUN), (m_phase == PH_FAILED), 2'(m_retry)};
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lock  = 1'($urandom_range(0, 1));
      rearm = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    checks++;
    if ({resetb, sysrst, locked, failo, retry} !== 6'b010000) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", {resetb, sysrst, locked, failo, retry}, 6'b010000);
    end
    lock  = 1'b0;
    rearm = 1'b0;
  endtask

  task automatic test_release_and_lock();
    int n;
    bit bad;
    rst = 1'b0;
    n   = 0;
    bad = 1'b0;
    while (resetb === 1'b0 && n < 50) begin
      if (sysrst !== 1'b1) bad = 1'b1;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != P_HOLD) begin errors++; $display("FAIL hold_len: got %0d expected %0d", n, P_HOLD); end
    checks++;
    if (bad || sysrst !== 1'b1) begin errors++; $display("FAIL sysrst_during_hold: got %b expected 1", sysrst); end
    repeat (5) @(negedge clk);
    lock = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (sysrst !== 1'b0 && n < 100);
    checks++;
    if (n != 6) begin errors++; $display("FAIL lock_latency: got %0d expected 6", n); end
    checks++;
    if ({locked, retry} !== 3'b100) begin errors++; $display("FAIL run_state: got %b expected 100", {locked, retry}); end
  endtask

  task automatic test_loss_of_lock();
    int n;
    lock = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (sysrst !== 1'b1 && n < 100);
    checks++;
    if (n != 3) begin errors++; $display("FAIL loss_latency: got %0d expected 3", n); end
    checks++;
    if ({locked, retry} !== 3'b000) begin errors++; $display("FAIL loss_state: got %b expected 000", {locked, retry}); end
    n = 0;
    while (resetb === 1'b0 && n < 50) begin n++; @(negedge clk); end
    checks++;
    if (n != P_HOLD) begin errors++; $display("FAIL relock_hold_len: got %0d expected %0d", n, P_HOLD); end
    repeat (5) @(negedge clk);
    lock = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (sysrst !== 1'b0 && n < 100);
    checks++;
    if (n != 6) begin errors++; $display("FAIL relock_latency: got %0d expected 6", n); end
  endtask

  task automatic test_stable_abort();
    int n;
    lock = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(sysrst === 1'b1 && resetb === 1'b1) && n < 100);
    checks++;
    if (n >= 100) begin errors++; $display("FAIL reach_wait_lock: got timeout expected wait state"); end
    lock = 1'b1; @(negedge clk);
    @(negedge clk);
    lock = 1'b0; @(negedge clk);
    lock = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (sysrst !== 1'b0 && n < 100);
    checks++;
    if (n != 6) begin errors++; $display("FAIL abort_latency: got %0d expected 6", n); end
    checks++;
    if (retry !== 2'd0) begin errors++; $display("FAIL abort_retry: got %0d expected 0", retry); end
  endtask

  task automatic test_timeout_fail();
    int  n;
    bit  bad;
    rst  = 1'b1;
    lock = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (resetb === 1'b0 && n < 50) begin n++; @(negedge clk); end
      checks++;
      if (n != P_HOLD) begin errors++; $display("FAIL attempt%0d_hold_len: got %0d expected %0d", k, n, P_HOLD); end
      n = 0;
      while (resetb === 1'b1 && n < 50) begin n++; @(negedge clk); end
      checks++;
      if (n != P_TO) begin errors++; $display("FAIL attempt%0d_wait_len: got %0d expected %0d", k, n, P_TO); end
      checks++;
      if ({failo, retry} !== {(k == 2), 2'((k < 2) ? k + 1 : 2)}) begin
        errors++;
        $display("FAIL attempt%0d_retry_fail: got %b expected %b", k, {failo, retry}, {(k == 2), 2'((k < 2) ? k + 1 : 2)});
      end
    end
    lock = 1'b1;
    bad  = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (resetb !== 1'b0 || failo !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL failed_terminal: got resetb=%b fail=%b expected 0 1", resetb, failo); end
  endtask

  task automatic test_rearm();
    int n;
    lock  = 1'b0;
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    checks++;
    if ({resetb, failo, retry} !== 4'b0000) begin
      errors++; $display("FAIL rearm_clear: got %b expected 0000", {resetb, failo, retry});
    end
    n = 0;
    while (resetb === 1'b0 && n < 50) begin n++; @(negedge clk); end
    checks++;
    if (n != P_HOLD) begin errors++; $display("FAIL rearm_hold_len: got %0d expected %0d", n, P_HOLD); end
    // Raise lock so the synchronized rise reaches the FSM on the REARM edge.
    lock = 1'b1; @(negedge clk);
    @(negedge clk);
    rearm = 1'b1; @(negedge clk);
    rearm = 1'b0;
    checks++;
    if ({resetb, sysrst} !== 2'b01) begin errors++; $display("FAIL rearm_over_lock: got %b expected 01", {resetb, sysrst}); end
    n = 0;
    while (resetb === 1'b0 && n < 50) begin n++; @(negedge clk); end
    checks++;
    if (n != P_HOLD) begin errors++; $display("FAIL rearm2_hold_len: got %0d expected %0d", n, P_HOLD); end
    n = 0;
    while (sysrst !== 1'b0 && n < 100) begin n++; @(negedge clk); end
    checks++;
    if (n != 1 + P_ST) begin errors++; $display("FAIL rearm_relock: got %0d expected %0d", n, 1 + P_ST); end
  endtask

  task automatic test_rearm_hold();
    int n;
    int hold_n;
    bit bad;
    hold_n = $urandom_range(2, 6);
    bad    = 1'b0;
    rearm  = 1'b1;
    for (int i = 0; i < hold_n; i++) begin
      @(negedge clk);
      if (resetb !== 1'b0) bad = 1'b1;
    end
    rearm = 1'b0;
    checks++;
    if (bad) begin errors++; $display("FAIL rearm_held_low: got resetb=%b expected 0", resetb); end
    n = 0;
    while (resetb === 1'b0 && n < 50) begin n++; @(negedge clk); end
    checks++;
    if (n != P_HOLD) begin errors++; $display("FAIL rearm_held_count: got %0d expected %0d", n, P_HOLD); end
  endtask

  task automatic test_random();
    int flipdiv;
    rst   = 1'b1;
    rearm = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    flipdiv = 10;
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 0) flipdiv = $urandom_range(3, 40);
      if ($urandom_range(0, flipdiv - 1) == 0) lock = ~lock;
      rearm = ($urandom_range(0, 199) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      @(negedge clk);
      checks++;
      if ({resetb, sysrst, locked, failo, retry} !== m_vec()) begin
        errors++;
        $display("FAIL random_cycle%0d: got %b expected %b", c, {resetb, sysrst, locked, failo, retry}, m_vec());
      end
    end
    rst   = 1'b0;
    rearm = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_release_and_lock();
    test_loss_of_lock();
    test_stable_abort();
    test_timeout_fail();
    test_rearm();
    test_rearm_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
